bin2bcd_seq: RTL



---
 rtl/disp_pkg.sv | 20 ++
 rtl/bcd_dig_adj.sv | 9 +
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared display-path constants: default widths, BCD range limit and the
// converter's FSM state encoding.
package disp_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int BIN_W_DEF  = 27;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned max_val(input int digits);
    longint unsigned m;
    m = 64'd1;
    for (int i = 0; i < digits; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam longint unsigned MAX_VAL = max_val(DIGITS_DEF);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
endpackage

// File: rtl/bcd_dig_adj.sv
// Double-dabble per-digit correction: add 3 to any digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_dig_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // Inputs never exceed 9, so d_i + 3 stays within 4 bits.
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (one bit per clock) with overflow
// saturation and a leading-zero blanking mask for the scan driver.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int BIN_W    = BIN_W_DEF,
  parameter int DIGITS   = DIGITS_DEF,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [BIN_W-1:0]    bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]   digit_en_o,
  output logic                ovf_o
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam longint unsigned MAXV = max_val(DIGITS);

  logic [1:0]        state_q, state_d;
  logic [BIN_W-1:0]  shreg_q, shreg_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_nxt_q, ovf_nxt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  res;
  logic [DIGITS-1:0] en_mask;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (adj[4*g +: 4])
    );
  end

  assign res = ovf_nxt_q ? {DIGITS{4'h9}} : acc_q;

  // Digit i lit when it or any more significant digit is nonzero.
  always_comb begin
    en_mask = '1;
    if (BLANK_LZ) begin
      for (int i = 1; i < DIGITS; i++) en_mask[i] = |(res >> (4 * i));
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_nxt_d = ovf_nxt_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d   = bin_i;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_nxt_d = 64'(bin_i) > MAXV;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = res;
        en_d    = en_mask;
        ovf_d   = ovf_nxt_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_nxt_q <= 1'b0;
      bcd_q     <= '0;
      en_q      <= DIGITS'(1);
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_nxt_q <= ovf_nxt_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign bcd_o      = bcd_q;
  assign digit_en_o = en_q;
  assign ovf_o      = ovf_q;
endmodule
